ysyx_22050612_wbu: RTL and testbench

Writeback unit: the writer side of the integer register file write port.
- Collects results from two producers: EXU (single-cycle ALU results) and LSU (load data).
- Buffers EXU results in a small FIFO.
- Round-robin arbitrates between LSU and the FIFO head.
- Drives one registered write per cycle on the register file write port (wen/waddr/wdata).

---
 rtl/ysyx_22050612_pkg.sv | 24 ++
 rtl/ysyx_22050612_sync_fifo.sv | 73 +++++++
 rtl/ysyx_22050612_wbu.sv | 116 +++++++++++
 tb/tb_ysyx_22050612_wbu.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050612_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_pkg
// Shared definitions for the ysyx_22050612 pipeline writeback path.
//   XLEN        : integer register / result width
//   REG_ADDR_W  : register index width
//   wb_entry_t  : one pending register-file write {rd, data}
//   source_t    : which producer a writeback slot belongs to
// ---------------------------------------------------------------------------
package ysyx_22050612_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic {
        SRC_EXU = 1'b0,
        SRC_LSU = 1'b1
    } source_t;

endpackage : ysyx_22050612_pkg

// File: rtl/ysyx_22050612_sync_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_sync_fifo
// Generic single-clock FIFO with synchronous active-high reset.
// Ports:
//   clk, rst : clock and synchronous reset (empties the FIFO)
//   push, din: write request and data; ignored while full
//   pop      : read request; ignored while empty
//   dout     : head entry (valid while !empty)
//   full, empty, count : occupancy status (count is log2(DEPTH)+1 bits)
// A push is not pop-aware: a full FIFO rejects a push even when the head
// is leaving on the same edge.
// ---------------------------------------------------------------------------
module ysyx_22050612_sync_fifo
    import ysyx_22050612_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; entries are only observable through count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : ysyx_22050612_sync_fifo

// File: rtl/ysyx_22050612_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_22050612_wbu
// Writeback unit: sole writer of the integer register file write port.
// EXU results are queued in a small FIFO; LSU results are taken directly
// with a valid/ready handshake. One write per cycle is chosen round-robin
// and registered onto rf_wen/rf_waddr/rf_wdata.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   exu_valid/exu_ready/exu_rd/exu_data : EXU result push (ready = !full)
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : LSU result (ready = granted now)
//   rf_wen/rf_waddr/rf_wdata    : registered register-file write port
//   retire_cnt                  : number of writes performed (rd != 0)
// ---------------------------------------------------------------------------
module ysyx_22050612_wbu
    import ysyx_22050612_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN,
    parameter int EXU_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [63:0]           retire_cnt
);

    localparam int EW = ADDR_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(EXU_DEPTH) + 1;

    logic [EW-1:0]         fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_pop;

    logic                  req_lsu;
    logic                  req_exu;
    logic                  grant_lsu;
    logic                  grant_exu;
    logic                  granted;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    source_t               rr_last;

    ysyx_22050612_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (EXU_DEPTH)
    ) u_exu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (exu_valid),
        .din   ({exu_rd, exu_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign exu_ready = !fifo_full;

    // On a conflict the source that did not win the previous conflict wins.
    // lsu_ready must not depend on exu_valid, only on FIFO occupancy.
    always_comb begin
        req_lsu   = lsu_valid;
        req_exu   = (fifo_count != '0);
        grant_lsu = req_lsu && (!req_exu || rr_last == SRC_EXU);
        grant_exu = req_exu && (!req_lsu || rr_last == SRC_LSU);
        granted   = grant_lsu || grant_exu;
        sel_rd    = lsu_rd;
        sel_data  = lsu_data;
        if (grant_exu) begin
            sel_rd   = fifo_dout[EW-1 -: ADDR_WIDTH];
            sel_data = fifo_dout[DATA_WIDTH-1:0];
        end
    end

    assign lsu_ready = grant_lsu;
    // The empty qualifier is already implied by the grant; kept as a guard.
    assign fifo_pop  = grant_exu && !fifo_empty;

    // Output register: x0 results are consumed but never written, and the
    // address/data hold whenever no write is performed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            retire_cnt <= '0;
            rr_last    <= SRC_EXU;
        end else begin
            if (req_lsu && req_exu) begin
                rr_last <= grant_lsu ? SRC_LSU : SRC_EXU;
            end
            if (granted && sel_rd != '0) begin
                rf_wen     <= 1'b1;
                rf_waddr   <= sel_rd;
                rf_wdata   <= sel_data;
                retire_cnt <= retire_cnt + 64'd1;
            end else begin
                rf_wen <= 1'b0;
            end
        end
    end

endmodule : ysyx_22050612_wbu

// File: tb/tb_ysyx_22050612_wbu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050612_wbu
// Directed self-checking bench for the writeback unit (EXU_DEPTH = 2).
// ---------------------------------------------------------------------------
module tb_ysyx_22050612_wbu;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_rd;
    logic [63:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    ysyx_22050612_wbu #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (64),
        .EXU_DEPTH  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_rd     (exu_rd),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .retire_cnt (retire_cnt)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive both producer interfaces in one call
    task automatic applyStimulus(input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                                 input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
        exu_valid = ev;
        exu_rd    = erd;
        exu_data  = ed;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Checks one registered write against hand-computed values
    task automatic expect_write(input string name, input logic [4:0] a, input logic [63:0] d);
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== a || rf_wdata !== d) begin
            errors++;
            $display("[TB] FAIL %s: got wen=%0b addr=%0d data=%0h expected wen=1 addr=%0d data=%0h",
                     name, rf_wen, rf_waddr, rf_wdata, a, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd3, 64'h55, 1'b0, 5'd4, 64'h66);
        tick();
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_port: got wen=%0b addr=%0d data=%0h expected 0/0/0",
                     rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (retire_cnt !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_retire: got %0d expected 0", retire_cnt);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (exu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got exu_ready=%0b lsu_ready=%0b expected 1/0",
                     exu_ready, lsu_ready);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_wen: got %0b expected 0", rf_wen);
        end
    endtask

    task automatic test_single_exu();
        do_reset();
        applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exu_early_wen: got %0b expected 0", rf_wen);
        end
        tick();
        expect_write("exu_single", 5'd5, 64'h1234);
        checks++;
        if (retire_cnt !== 64'd1) begin
            errors++;
            $display("[TB] FAIL exu_retire: got %0d expected 1", retire_cnt);
        end
        tick();
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd5) begin
            errors++;
            $display("[TB] FAIL exu_after: got wen=%0b addr=%0d expected wen=0 addr=5", rf_wen, rf_waddr);
        end
    endtask

    task automatic test_round_robin();
        logic exp_ready [4];
        exp_ready = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        applyStimulus(1'b1, 5'd1, 64'hA, 1'b0, 5'd0, 64'd0);
        tick();
        checks++;
        if (rf_wen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_fill_wen: got %0b expected 0", rf_wen);
        end
        // Conflict 1: LSU wins first
        applyStimulus(1'b1, 5'd2, 64'hB, 1'b1, 5'd3, 64'hC);
        #1;
        checks++;
        if (lsu_ready !== exp_ready[0]) begin
            errors++;
            $display("[TB] FAIL rr_ready0: got %0b expected %0b", lsu_ready, exp_ready[0]);
        end
        tick();
        expect_write("rr_w1", 5'd3, 64'hC);
        checks++;
        if (exu_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rr_full: got exu_ready=%0b expected 0", exu_ready);
        end
        // Conflict 2: FIFO head wins
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 64'hD);
        #1;
        checks++;
        if (lsu_ready !== exp_ready[1]) begin
            errors++;
            $display("[TB] FAIL rr_ready1: got %0b expected %0b", lsu_ready, exp_ready[1]);
        end
        tick();
        expect_write("rr_w2", 5'd1, 64'hA);
        // Conflict 3: LSU again
        #1;
        checks++;
        if (lsu_ready !== exp_ready[2]) begin
            errors++;
            $display("[TB] FAIL rr_ready2: got %0b expected %0b", lsu_ready, exp_ready[2]);
        end
        tick();
        expect_write("rr_w3", 5'd4, 64'hD);
        // Conflict 4: FIFO again
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hE);
        #1;
        checks++;
        if (lsu_ready !== exp_ready[3]) begin
            errors++;
            $display("[TB] FAIL rr_ready3: got %0b expected %0b", lsu_ready, exp_ready[3]);
        end
        tick();
        expect_write("rr_w4", 5'd2, 64'hB);
        tick();
        expect_write("rr_w5", 5'd5, 64'hE);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        checks++;
        if (retire_cnt !== 64'd5) begin
            errors++;
            $display("[TB] FAIL rr_retire: got %0d expected 5", retire_cnt);
        end
    endtask

    task automatic test_full_backpressure();
        int es = 0;
        int ls = 0;
        int eo = 0;
        int lo = 0;
        logic eacc;
        logic lacc;
        logic exp_er;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            applyStimulus(es < 8, 5'(8 + es), 64'(es), 1'b1, 5'(20 + (ls % 8)), 64'h100 + 64'(ls));
            #1;
            // Steady pattern: two pushes fill the FIFO, then it alternates full/not full
            if (c < 14) begin
                exp_er = (c == 0) || (c % 2 == 1);
                checks++;
                if (exu_ready !== exp_er) begin
                    errors++;
                    $display("[TB] FAIL bp_exu_ready_c%0d: got %0b expected %0b", c, exu_ready, exp_er);
                end
            end
            eacc = exu_valid && exu_ready;
            lacc = lsu_ready;
            tick();
            if (eacc) es++;
            if (lacc) ls++;
            if (rf_wen === 1'b1) begin
                checks++;
                if (rf_waddr >= 5'd8 && rf_waddr < 5'd16) begin
                    if (rf_waddr !== 5'(8 + eo) || rf_wdata !== 64'(eo)) begin
                        errors++;
                        $display("[TB] FAIL bp_exu_order: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                 rf_waddr, rf_wdata, 8 + eo, eo);
                    end
                    eo++;
                end else if (rf_waddr >= 5'd20) begin
                    if (rf_waddr !== 5'(20 + (lo % 8)) || rf_wdata !== 64'h100 + 64'(lo)) begin
                        errors++;
                        $display("[TB] FAIL bp_lsu_order: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                 rf_waddr, rf_wdata, 20 + (lo % 8), 64'h100 + 64'(lo));
                    end
                    lo++;
                end else begin
                    errors++;
                    $display("[TB] FAIL bp_addr: got addr=%0d expected an EXU or LSU tag", rf_waddr);
                end
            end
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        checks++;
        if (eo !== 8) begin
            errors++;
            $display("[TB] FAIL bp_exu_count: got %0d expected 8", eo);
        end
    endtask

    task automatic test_x0_write();
        do_reset();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77);
        tick();
        expect_write("x0_pre", 5'd7, 64'h77);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF);
        #1;
        checks++;
        if (lsu_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL x0_ready: got %0b expected 1", lsu_ready);
        end
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 64'h77) begin
            errors++;
            $display("[TB] FAIL x0_port: got wen=%0b addr=%0d data=%0h expected wen=0 addr=7 data=77",
                     rf_wen, rf_waddr, rf_wdata);
        end
        checks++;
        if (retire_cnt !== 64'd1) begin
            errors++;
            $display("[TB] FAIL x0_retire: got %0d expected 1", retire_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        applyStimulus(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0);
        tick();
        // LSU x0 wins the conflict, so the FIFO keeps both entries unwritten
        applyStimulus(1'b1, 5'd10, 64'hAA, 1'b1, 5'd0, 64'h0);
        tick();
        checks++;
        if (rf_wen !== 1'b0 || exu_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_setup: got wen=%0b exu_ready=%0b expected 0/0", rf_wen, exu_ready);
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd11, 64'hBB);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        checks++;
        if (rf_wen !== 1'b0 || exu_ready !== 1'b1 || retire_cnt !== 64'd0) begin
            errors++;
            $display("[TB] FAIL mid_after: got wen=%0b exu_ready=%0b retire=%0d expected 0/1/0",
                     rf_wen, exu_ready, retire_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (rf_wen !== 1'b0 || rf_waddr === 5'd9 || rf_waddr === 5'd10) begin
                errors++;
                $display("[TB] FAIL mid_stale_c%0d: got wen=%0b addr=%0d expected wen=0 addr not 9/10",
                         c, rf_wen, rf_waddr);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        test_reset();
        test_single_exu();
        test_round_robin();
        test_full_backpressure();
        test_x0_write();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ysyx_22050612_wbu
